// File: rtl/high_bus_pkg.sv
// Shared constants and types for the high-bus responder: word width, read-flag bit,
// out-of-range fill value and FSM state encoding.
package high_bus_pkg;

  localparam int BRUST_SIZE_LOG = 2;
  localparam int ADDR_WIDTH     = 16;
  localparam int MEM_DEPTH_LOG  = 4;

  function automatic int data_w_of(input int brust_size_log);
    return 8 * (2 ** brust_size_log);
  endfunction

  function automatic int rd_flag_bit_of(input int addr_width);
    return addr_width - 1;
  endfunction

  localparam int DATA_W      = data_w_of(BRUST_SIZE_LOG);
  localparam int RD_FLAG_BIT = rd_flag_bit_of(ADDR_WIDTH);

  localparam logic [DATA_W-1:0] OOR_FILL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_GAP  = 2'd2
  } resp_state_e;

endpackage

// File: rtl/high_bus_responder_if.sv
// High-bus link between the UART bridge (master) and the responder (slave);
// also carries the responder FSM state for observation.
interface high_bus_responder_if #(
  parameter int DW = high_bus_pkg::DATA_W,
  parameter int AW = high_bus_pkg::ADDR_WIDTH
);

  // No backpressure: high_write_valid and high_read_finish are single-cycle pulses that are
  // always consumed; high_read_valid stays high with high_read_data stable until a finish pulse.
  logic [DW-1:0]              high_write_data;
  logic [AW-1:0]              high_write_addr;
  logic                       high_write_valid;
  logic [DW-1:0]              high_read_data;
  logic                       high_read_valid;
  logic                       high_read_finish;
  high_bus_pkg::resp_state_e  fsm_state;

  modport master (
    output high_write_data, high_write_addr, high_write_valid, high_read_finish,
    input  high_read_data, high_read_valid, fsm_state
  );

  modport slave (
    input  high_write_data, high_write_addr, high_write_valid, high_read_finish,
    output high_read_data, high_read_valid, fsm_state
  );

endinterface

// File: rtl/high_bus_responder_resp_regfile.sv
// Small register file: synchronous write, combinational read, cleared by async reset.
module resp_regfile #(
  parameter int DW        = 32,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  logic [DW-1:0]        wdata,
  input  logic [DEPTH_LOG-1:0] raddr,
  output logic [DW-1:0]        rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/high_bus_responder.sv
// Target endpoint of the high bus: register writes, read responses held until finish,
// one pending read slot. HIGH_BUS_RESP_STATUS_EN adds a saturating drop counter.
module high_bus_responder
  import high_bus_pkg::*;
#(
  parameter int BRUST_SIZE_LOG = high_bus_pkg::BRUST_SIZE_LOG,
  parameter int ADDR_WIDTH     = high_bus_pkg::ADDR_WIDTH,
  parameter int MEM_DEPTH_LOG  = high_bus_pkg::MEM_DEPTH_LOG
) (
  input  logic                 clk,
  input  logic                 rst,
  high_bus_responder_if.slave  bus
`ifdef HIGH_BUS_RESP_STATUS_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);

  localparam int DW = data_w_of(BRUST_SIZE_LOG);
  localparam int RB = rd_flag_bit_of(ADDR_WIDTH);
  localparam logic [DW-1:0] FILL = '1;

  resp_state_e             state_q, state_d;
  logic                    rvalid_q, rvalid_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic                    slot_full_q, slot_full_d;
  logic [ADDR_WIDTH-2:0]   slot_addr_q, slot_addr_d;

  logic                     is_rd, is_wr, cmd_in_range, we;
  logic [MEM_DEPTH_LOG-1:0] cmd_idx, iss_idx;
  logic [ADDR_WIDTH-2:0]    iss_addr;
  logic                     iss_in_range;
  logic [DW-1:0]            rf_rdata, iss_word;

  assign is_rd        = bus.high_write_valid &  bus.high_write_addr[RB];
  assign is_wr        = bus.high_write_valid & ~bus.high_write_addr[RB];
  assign cmd_idx      = bus.high_write_addr[MEM_DEPTH_LOG-1:0];
  assign cmd_in_range = (bus.high_write_addr[ADDR_WIDTH-2:MEM_DEPTH_LOG] == '0);
  assign we           = is_wr & cmd_in_range;

  // Issue source: the incoming command in IDLE, the pending slot otherwise.
  assign iss_addr     = (state_q == ST_GAP) ? slot_addr_q : bus.high_write_addr[ADDR_WIDTH-2:0];
  assign iss_idx      = iss_addr[MEM_DEPTH_LOG-1:0];
  assign iss_in_range = (iss_addr[ADDR_WIDTH-2:MEM_DEPTH_LOG] == '0);

  resp_regfile #(.DW(DW), .DEPTH_LOG(MEM_DEPTH_LOG)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (cmd_idx),
    .wdata (bus.high_write_data),
    .raddr (iss_idx),
    .rdata (rf_rdata)
  );

  // A write landing on the same edge as a pending-read issue is forwarded to the response.
  always_comb begin
    iss_word = rf_rdata;
    if (!iss_in_range)                 iss_word = FILL;
    else if (we && cmd_idx == iss_idx) iss_word = bus.high_write_data;
  end

  always_comb begin
    state_d     = state_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    slot_full_d = slot_full_q;
    slot_addr_d = slot_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (is_rd) begin
          rdata_d  = iss_word;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (is_rd && !slot_full_q) begin
          slot_full_d = 1'b1;
          slot_addr_d = bus.high_write_addr[ADDR_WIDTH-2:0];
        end
        if (bus.high_read_finish) begin
          rvalid_d = 1'b0;
          state_d  = slot_full_d ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        rdata_d     = iss_word;
        rvalid_d    = 1'b1;
        slot_full_d = 1'b0;
        state_d     = ST_RESP;
      end
      default: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      slot_full_q <= 1'b0;
      slot_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      slot_full_q <= slot_full_d;
      slot_addr_q <= slot_addr_d;
    end
  end

  assign bus.high_read_valid = rvalid_q;
  assign bus.high_read_data  = rdata_q;
  assign bus.fsm_state       = state_q;

`ifdef HIGH_BUS_RESP_STATUS_EN
  logic       rd_drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // GAP always has the slot occupied, so reads arriving there are dropped too.
  assign rd_drop = is_rd && ((state_q == ST_RESP && slot_full_q) || state_q == ST_GAP);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (rd_drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= 8'd0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_high_bus_responder.sv
// Self-checking bench for high_bus_responder: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_high_bus_responder;
  import high_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  high_bus_responder_if bus ();

`ifdef HIGH_BUS_RESP_STATUS_EN
  logic [7:0] drop_cnt;
  high_bus_responder dut (.clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt));
`else
  high_bus_responder dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // Reference model: a response register, a gap flag, a one-deep pending queue.
  logic [31:0] m_mem [16];
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_gap;
  logic [15:0] m_pend[$];
  int          m_drops;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    if (a[14:4] != 11'd0) return 32'hFFFF_FFFF;
    return m_mem[a[3:0]];
  endfunction

  task automatic note_drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic model_step();
    logic [15:0] a;
    bit          rd;
    a  = bus.high_write_addr;
    rd = bus.high_write_valid && a[15];
    if (bus.high_write_valid && !a[15] && a[14:4] == 11'd0) m_mem[a[3:0]] = bus.high_write_data;
    if (m_gap) begin
      m_data  = word_of(m_pend.pop_front());
      m_valid = 1'b1;
      m_gap   = 1'b0;
      if (rd) note_drop();
    end else if (m_valid) begin
      if (rd) begin
        if (m_pend.size() == 0) m_pend.push_back(a);
        else note_drop();
      end
      if (bus.high_read_finish) begin
        m_valid = 1'b0;
        m_gap   = (m_pend.size() != 0);
      end
    end else if (rd) begin
      m_data  = word_of(a);
      m_valid = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
      m_valid = 1'b0;
      m_data  = 32'd0;
      m_gap   = 1'b0;
      m_pend.delete();
      m_drops = 0;
    end else begin
      model_step();
    end
  end

  // Driver: inputs applied between edges, pulses cleared 1ns after the edge they hit.
  task automatic cyc(input bit wv, input logic [15:0] a, input logic [31:0] d, input bit fin);
    bus.high_write_valid = wv;
    bus.high_write_addr  = a;
    bus.high_write_data  = d;
    bus.high_read_finish = fin;
    @(posedge clk);
    #1;
    bus.high_write_valid = 1'b0;
    bus.high_read_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.high_read_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 0", bus.high_read_valid);
    end
    tests_run++;
    if (bus.high_read_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 00000000", bus.high_read_data);
    end
`ifdef HIGH_BUS_RESP_STATUS_EN
    tests_run++;
    if (drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    cyc(1, 16'h0003, 32'h1122_3344, 0);
    cyc(1, 16'h8003, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bus.high_read_valid !== 1'b1 || bus.high_read_data !== 32'h1122_3344) begin
        tests_failed++;
        $display("FAIL wr_rd_hold[%0d]: got v=%b d=%h expected v=1 d=11223344",
                 i, bus.high_read_valid, bus.high_read_data);
      end
      cyc(0, 16'h0, 32'h0, 0);
    end
    cyc(0, 16'h0, 32'h0, 1);
    tests_run++;
    if (bus.high_read_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_rd_after_finish: got v=%b expected 0", bus.high_read_valid);
    end
  endtask

  task automatic test_out_of_range();
    cyc(1, 16'h8010, 32'h0, 0);
    tests_run++;
    if (bus.high_read_valid !== 1'b1 || bus.high_read_data !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL oor_read: got v=%b d=%h expected v=1 d=ffffffff",
               bus.high_read_valid, bus.high_read_data);
    end
    cyc(0, 16'h0, 32'h0, 1);
    cyc(1, 16'h0010, $urandom() | 32'h1, 0);
    cyc(1, 16'h8000, 32'h0, 0);
    tests_run++;
    if (bus.high_read_valid !== 1'b1 || bus.high_read_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL oor_write_discard: got v=%b d=%h expected v=1 d=00000000",
               bus.high_read_valid, bus.high_read_data);
    end
    cyc(0, 16'h0, 32'h0, 1);
  endtask

  task automatic test_pending();
    logic [31:0] v1, v2;
    v1 = $urandom();
    v2 = $urandom();
    cyc(1, 16'h0001, v1, 0);
    cyc(1, 16'h0002, v2, 0);
    cyc(1, 16'h8001, 32'h0, 0);
    cyc(1, 16'h8002, 32'h0, 0);
    tests_run++;
    if (bus.high_read_valid !== 1'b1 || bus.high_read_data !== v1) begin
      tests_failed++;
      $display("FAIL pend_first: got v=%b d=%h expected v=1 d=%h",
               bus.high_read_valid, bus.high_read_data, v1);
    end
    cyc(0, 16'h0, 32'h0, 1);
    tests_run++;
    if (bus.high_read_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_gap: got v=%b expected 0", bus.high_read_valid);
    end
    cyc(0, 16'h0, 32'h0, 0);
    tests_run++;
    if (bus.high_read_valid !== 1'b1 || bus.high_read_data !== v2) begin
      tests_failed++;
      $display("FAIL pend_second: got v=%b d=%h expected v=1 d=%h",
               bus.high_read_valid, bus.high_read_data, v2);
    end
    cyc(0, 16'h0, 32'h0, 1);
    cyc(0, 16'h0, 32'h0, 0);
    tests_run++;
    if (bus.high_read_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_idle: got v=%b expected 0", bus.high_read_valid);
    end
  endtask

  task automatic test_back_to_back();
    int  responses;
    bit  prev_v;
    responses = 0;
    prev_v    = 1'b0;
    cyc(1, 16'h8001, 32'h0, 0);
    cyc(1, 16'h8002, 32'h0, 0);
    cyc(1, 16'h8003, 32'h0, 0);
`ifdef HIGH_BUS_RESP_STATUS_EN
    tests_run++;
    if (drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL b2b_drop_cnt: got %0d expected 1", drop_cnt);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      if (bus.high_read_valid === 1'b1 && !prev_v) responses++;
      prev_v = (bus.high_read_valid === 1'b1);
      cyc(0, 16'h0, 32'h0, (i == 1 || i == 4));
    end
    tests_run++;
    if (responses != 2) begin
      tests_failed++;
      $display("FAIL b2b_responses: got %0d expected 2", responses);
    end
  endtask

  task automatic test_pending_sees_write();
    cyc(1, 16'h8001, 32'h0, 0);
    cyc(1, 16'h8005, 32'h0, 0);
    cyc(1, 16'h0005, 32'hCAFE_BABE, 0);
    cyc(0, 16'h0, 32'h0, 1);
    cyc(0, 16'h0, 32'h0, 0);
    tests_run++;
    if (bus.high_read_valid !== 1'b1 || bus.high_read_data !== 32'hCAFE_BABE) begin
      tests_failed++;
      $display("FAIL pend_raw: got v=%b d=%h expected v=1 d=cafebabe",
               bus.high_read_valid, bus.high_read_data);
    end
    cyc(0, 16'h0, 32'h0, 1);
  endtask

  task automatic test_reset_mid();
    cyc(1, 16'h8001, 32'h0, 0);
    cyc(1, 16'h8002, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.high_read_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_valid: got v=%b expected 0", bus.high_read_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 16'h0, 32'h0, 0);
      tests_run++;
      if (bus.high_read_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_mid_no_resp[%0d]: got v=%b expected 0", i, bus.high_read_valid);
      end
    end
    cyc(1, 16'h8005, 32'h0, 0);
    tests_run++;
    if (bus.high_read_valid !== 1'b1 || bus.high_read_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_mem_clear: got v=%b d=%h expected v=1 d=00000000",
               bus.high_read_valid, bus.high_read_data);
    end
    cyc(0, 16'h0, 32'h0, 1);
  endtask

  task automatic test_random();
    bit          wv, fin;
    logic [15:0] a;
    for (int i = 0; i < 500; i++) begin
      wv       = ($urandom_range(0, 99) < 45);
      a        = 16'($urandom_range(0, 15));
      a[15]    = ($urandom_range(0, 1) == 1);
      a[14:4]  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1, 2047)) : 11'd0;
      fin      = m_valid ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cyc(wv, a, $urandom(), fin);
      tests_run++;
      if (bus.high_read_valid !== m_valid) begin
        tests_failed++;
        $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.high_read_valid, m_valid);
      end else if (m_valid) begin
        tests_run++;
        if (bus.high_read_data !== m_data) begin
          tests_failed++;
          $display("FAIL rand_data[%0d]: got %h expected %h", i, bus.high_read_data, m_data);
        end
      end
    end
`ifdef HIGH_BUS_RESP_STATUS_EN
    tests_run++;
    if (drop_cnt !== 8'(m_drops)) begin
      tests_failed++;
      $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt, m_drops);
    end
`endif
  endtask

  initial begin
    bus.high_write_valid = 1'b0;
    bus.high_write_addr  = '0;
    bus.high_write_data  = '0;
    bus.high_read_finish = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_pending();
    test_back_to_back();
    test_pending_sees_write();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
